dbus_arbiter: RTL and testbench

DBUS_ARBITER -- requirements
Module: dbus_arbiter

---
 rtl/dbus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dbus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: CPU dbus (port 0) and display DMA (port 1) share one memory port.
// Define DBUS_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module dbus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                p0_valid_i,
    output logic                p0_ready_o,
    input  logic [ADDR_W-1:0]   p0_addr_i,
    input  logic                p0_we_i,
    input  logic [DATA_W-1:0]   p0_wdata_i,
    input  logic [DATA_W/8-1:0] p0_wstrb_i,
    output logic                p0_rvalid_o,
    output logic [DATA_W-1:0]   p0_rdata_o,
    output logic [31:0]         p0_cnt_o,

    input  logic                p1_valid_i,
    output logic                p1_ready_o,
    input  logic [ADDR_W-1:0]   p1_addr_i,
    input  logic                p1_we_i,
    input  logic [DATA_W-1:0]   p1_wdata_i,
    input  logic [DATA_W/8-1:0] p1_wstrb_i,
    output logic                p1_rvalid_o,
    output logic [DATA_W-1:0]   p1_rdata_o,
    output logic [31:0]         p1_cnt_o,

    output logic                mem_valid_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    // state | meaning
    // IDLE  | no transaction outstanding, arbitrate and accept one command
    // CMD   | command presented on mem_*, waiting for mem_ready_i
    // RSP   | read accepted by memory, waiting for mem_rvalid_i
    typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

    state_t              state_q, state_d;
    logic                grant1;
    logic                accept;
    logic                rd_done;
    logic                owner_q;
    logic                rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [31:0]         p0_cnt_q, p1_cnt_q;

`ifdef DBUS_ARB_RR_EN
    logic last_q;

    // last_q resets to port 1 so the first tie goes to port 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant1;
        end
    end

    assign grant1 = p1_valid_i & (~p0_valid_i | ~last_q);
`else
    assign grant1 = p1_valid_i & ~p0_valid_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        rd_done    = 1'b0;
        p0_ready_o = 1'b0;
        p1_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (rst_ni && (p0_valid_i || p1_valid_i)) begin
                    accept     = 1'b1;
                    p0_ready_o = ~grant1;
                    p1_ready_o = grant1;
                    state_d    = CMD;
                end
            end
            CMD: begin
                if (mem_ready_i) begin
                    if (mem_we_o) begin
                        state_d = IDLE;
                    end else if (mem_rvalid_i) begin
                        rd_done = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RSP;
                    end
                end
            end
            RSP: begin
                if (mem_rvalid_i) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q     <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata_q     <= '0;
            p0_cnt_q    <= '0;
            p1_cnt_q    <= '0;
        end else begin
            rvalid0_q <= rd_done & ~owner_q;
            rvalid1_q <= rd_done & owner_q;
            if (rd_done) begin
                rdata_q <= mem_rdata_i;
            end
            // mem_* payload is left in place after completion; only mem_valid_o drops
            if (accept) begin
                owner_q     <= grant1;
                mem_valid_o <= 1'b1;
                mem_addr_o  <= grant1 ? p1_addr_i  : p0_addr_i;
                mem_we_o    <= grant1 ? p1_we_i    : p0_we_i;
                mem_wdata_o <= grant1 ? p1_wdata_i : p0_wdata_i;
                mem_wstrb_o <= grant1 ? p1_wstrb_i : p0_wstrb_i;
            end else if (state_q == CMD && mem_ready_i) begin
                mem_valid_o <= 1'b0;
            end
            if (p0_valid_i && p0_ready_o) begin
                p0_cnt_q <= p0_cnt_q + 32'd1;
            end
            if (p1_valid_i && p1_ready_o) begin
                p1_cnt_q <= p1_cnt_q + 32'd1;
            end
        end
    end

    assign p0_rvalid_o = rvalid0_q;
    assign p1_rvalid_o = rvalid1_q;
    assign p0_rdata_o  = rdata_q;
    assign p1_rdata_o  = rdata_q;
    assign p0_cnt_o    = p0_cnt_q;
    assign p1_cnt_o    = p1_cnt_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed, table-driven bench for dbus_arbiter; expectations follow DBUS_ARB_RR_EN when defined.
module tb_dbus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          p0_valid = 1'b0, p1_valid = 1'b0;
    logic          p0_ready_o, p1_ready_o;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic          p0_we = 1'b0, p1_we = 1'b0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic [SW-1:0] p0_wstrb = '0, p1_wstrb = '0;
    logic          p0_rvalid_o, p1_rvalid_o;
    logic [DW-1:0] p0_rdata_o, p1_rdata_o;
    logic [31:0]   p0_cnt_o, p1_cnt_o;
    logic          mem_valid_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [DW-1:0] mem_wdata_o;
    logic [SW-1:0] mem_wstrb_o;
    logic          mem_ready_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    dbus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .p0_valid_i(p0_valid), .p0_ready_o(p0_ready_o), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
        .p0_wdata_i(p0_wdata), .p0_wstrb_i(p0_wstrb), .p0_rvalid_o(p0_rvalid_o),
        .p0_rdata_o(p0_rdata_o), .p0_cnt_o(p0_cnt_o),
        .p1_valid_i(p1_valid), .p1_ready_o(p1_ready_o), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
        .p1_wdata_i(p1_wdata), .p1_wstrb_i(p1_wstrb), .p1_rvalid_o(p1_rvalid_o),
        .p1_rdata_o(p1_rdata_o), .p1_cnt_o(p1_cnt_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       p0_valid;
        logic       p1_valid;
        logic [1:0] exp_ready;      // {p1_ready, p0_ready}
    } arb_vec_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_dly;       // cycles mem_ready_i stays low in CMD
        int          rv_dly;        // cycles from the mem_ready_i cycle to mem_rvalid_i
        logic [31:0] rdata;
        logic        exp_rv;
        logic [31:0] exp_rdata;
    } txn_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        p0_valid = 1'b0; p1_valid = 1'b0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        check("reset mem_valid", 128'(mem_valid_o), 128'(0));
        check("reset mem_cmd", 128'({mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}), 128'(0));
        check("reset rvalid", 128'({p1_rvalid_o, p0_rvalid_o}), 128'(0));
        check("reset cnt", 128'({p1_cnt_o, p0_cnt_o}), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Starts and ends on a falling edge with the DUT in IDLE
    task automatic run_txn(input int idx, input txn_t t);
        logic [68:0] exp_cmd;
        exp_cmd = {t.we, t.addr, t.wdata, t.wstrb};
        if (t.port) begin
            p1_valid = 1'b1; p1_we = t.we; p1_addr = t.addr; p1_wdata = t.wdata; p1_wstrb = t.wstrb;
        end else begin
            p0_valid = 1'b1; p0_we = t.we; p0_addr = t.addr; p0_wdata = t.wdata; p0_wstrb = t.wstrb;
        end
        #1;
        check($sformatf("txn%0d ready", idx), 128'({p1_ready_o, p0_ready_o}),
              128'(t.port ? 2'b10 : 2'b01));
        @(negedge clk_i);
        p0_valid = 1'b0; p1_valid = 1'b0;
        check($sformatf("txn%0d mem_valid", idx), 128'(mem_valid_o), 128'(1));
        check($sformatf("txn%0d mem_cmd", idx),
              128'({mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}), 128'(exp_cmd));
        for (int i = 0; i < t.rdy_dly; i++) begin
            mem_rvalid_i = 1'b1;            // stray response before acceptance must be ignored
            mem_rdata_i  = 32'hBAD0_BAD0;
            @(negedge clk_i);
            check($sformatf("txn%0d hold%0d", idx, i),
                  128'({mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}),
                  128'({1'b1, exp_cmd}));
        end
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b0;
        if (!t.we && t.rv_dly == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = t.rdata;
        end
        @(negedge clk_i);
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        check($sformatf("txn%0d mem_valid drop", idx), 128'(mem_valid_o), 128'(0));
        if (!t.we && t.rv_dly > 0) begin
            repeat (t.rv_dly - 1) begin
                @(negedge clk_i);
                check($sformatf("txn%0d early rvalid", idx), 128'({p1_rvalid_o, p0_rvalid_o}), 128'(0));
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = t.rdata;
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
        end
        check($sformatf("txn%0d rvalid", idx), 128'({p1_rvalid_o, p0_rvalid_o}),
              128'({t.port & t.exp_rv, ~t.port & t.exp_rv}));
        if (t.exp_rv) begin
            check($sformatf("txn%0d rdata", idx), 128'(t.port ? p1_rdata_o : p0_rdata_o),
                  128'(t.exp_rdata));
        end
        @(negedge clk_i);
        check($sformatf("txn%0d rvalid end", idx), 128'({p1_rvalid_o, p0_rvalid_o}), 128'(0));
    endtask

    initial begin
        arb_vec_t      av[4];
        txn_t          tv[6];
        txn_t          tw;
        logic          grants[8];
        logic          exp_g;
        int            ng;
        logic [68:0]   cmd0;

        av[0] = '{1'b0, 1'b0, 2'b00};
        av[1] = '{1'b1, 1'b0, 2'b01};
        av[2] = '{1'b0, 1'b1, 2'b10};
        av[3] = '{1'b1, 1'b1, 2'b01};

        tv[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
        tv[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 0, 32'h0, 1'b0, 32'h0};
        tv[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 1, 0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        tv[3] = '{1'b0, 1'b1, 32'h0000_0300, 32'h8765_4321, 4'h3, 2, 0, 32'h0, 1'b0, 32'h0};
        tv[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 32'h0BAD_C0DE, 1'b1, 32'h0BAD_C0DE};
        tv[5] = '{1'b1, 1'b0, 32'h0000_0208, 32'h0, 4'h0, 3, 1, 32'hA5A5_5A5A, 1'b1, 32'hA5A5_5A5A};

        apply_reset();

        // Combinational grant in IDLE; valids drop before the edge so nothing is accepted
        for (int i = 0; i < 4; i++) begin
            p0_valid = av[i].p0_valid;
            p1_valid = av[i].p1_valid;
            #1;
            check($sformatf("arb%0d ready", i), 128'({p1_ready_o, p0_ready_o}), 128'(av[i].exp_ready));
            p0_valid = 1'b0; p1_valid = 1'b0;
            @(negedge clk_i);
        end
        check("arb cnt", 128'({p1_cnt_o, p0_cnt_o}), 128'(0));

        for (int i = 0; i < 6; i++) begin
            run_txn(i, tv[i]);
        end
        check("txn cnt0", 128'(p0_cnt_o), 128'(3));
        check("txn cnt1", 128'(p1_cnt_o), 128'(3));

        // Stalled command: payload frozen, competing port 1 is not granted
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h400; p0_wdata = 32'h1122_3344; p0_wstrb = 4'h5;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h500;
        #1;
        check("stall grant", 128'({p1_ready_o, p0_ready_o}), 128'(2'b01));
        @(negedge clk_i);
        p0_valid = 1'b0;
        p0_addr = 32'hFFFF_0000; p0_wdata = 32'h0; p0_wstrb = 4'hA;
        cmd0 = {1'b1, 32'h400, 32'h1122_3344, 4'h5};
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall cmd%0d", i),
                  128'({mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}), 128'({1'b1, cmd0}));
            check($sformatf("stall p1 ready%0d", i), 128'(p1_ready_o), 128'(0));
            @(negedge clk_i);
        end
        mem_ready_i = 1'b1;
        p1_valid = 1'b0;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        check("stall done", 128'(mem_valid_o), 128'(0));
        check("stall cnt", 128'({p1_cnt_o, p0_cnt_o}), 128'({32'd3, 32'd4}));

        // Both ports stream writes with an always-ready memory
        apply_reset();
        p0_we = 1'b1; p1_we = 1'b1; p0_addr = 32'h600; p1_addr = 32'h700;
        p0_valid = 1'b1; p1_valid = 1'b1; mem_ready_i = 1'b1;
        ng = 0;
        for (int c = 0; c < 24 && ng < 8; c++) begin
            #1;
            if (p0_ready_o || p1_ready_o) begin
                grants[ng] = p1_ready_o;
                ng++;
            end
            @(negedge clk_i);
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        check("stream grants", 128'(ng), 128'(8));
        for (int i = 0; i < 8; i++) begin
`ifdef DBUS_ARB_RR_EN
            exp_g = 1'(i % 2);
`else
            exp_g = 1'b0;
`endif
            check($sformatf("stream grant%0d", i), 128'(grants[i]), 128'(exp_g));
        end
`ifdef DBUS_ARB_RR_EN
        check("stream cnt", 128'({p1_cnt_o, p0_cnt_o}), 128'({32'd4, 32'd4}));
`else
        check("stream cnt", 128'({p1_cnt_o, p0_cnt_o}), 128'({32'd0, 32'd8}));
`endif

        // Reset while the command is still presented
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h800;
        @(negedge clk_i);
        p0_valid = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("rst cmd mem_valid", 128'(mem_valid_o), 128'(0));
        check("rst cmd mem_addr", 128'(mem_addr_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset while waiting for read data; the late response must be dropped
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h900;
        @(negedge clk_i);
        p0_valid = 1'b0; mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        p1_valid = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        check("rst rsp ready", 128'({p1_ready_o, p0_ready_o}), 128'(0));
        check("rst rsp mem_valid", 128'(mem_valid_o), 128'(0));
        check("rst rsp cnt", 128'({p1_cnt_o, p0_cnt_o}), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1; p1_valid = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        check("rst rsp rvalid a", 128'({p1_rvalid_o, p0_rvalid_o}), 128'(0));
        @(negedge clk_i);
        check("rst rsp rvalid b", 128'({p1_rvalid_o, p0_rvalid_o}), 128'(0));
        check("rst rsp idle", 128'({mem_valid_o, p1_cnt_o, p0_cnt_o}), 128'(0));

        // Counter wrap
        force dut.p0_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.p0_cnt_q;
        #1;
        check("wrap preload", 128'(p0_cnt_o), 128'(32'hFFFF_FFFF));
        @(negedge clk_i);
        tw = '{1'b0, 1'b1, 32'h0000_0A00, 32'h0F0F_0F0F, 4'hF, 0, 0, 32'h0, 1'b0, 32'h0};
        run_txn(6, tw);
        check("wrap cnt0", 128'(p0_cnt_o), 128'(0));
        check("wrap cnt1", 128'(p1_cnt_o), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
